// File: rtl/pwm_deadtime_ip.sv
// Dead-time generator: splits pwm_in into a non-overlapping hs/ls pair with a programmable both-off gap.
// Define DTG_FAULT_EN to add the fault_n input (2-flop synchronised) and the sticky FAULT state.
module pwm_deadtime_ip #(
    parameter int DT_W     = 8,
    parameter int DT_RESET = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic        pwm_in,
`ifdef DTG_FAULT_EN
    input  logic        fault_n,
`endif
    output logic        hs_out,
    output logic        ls_out
);
    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_HS_ON  = 3'd1;
    localparam logic [2:0] ST_DT_H2L = 3'd2;
    localparam logic [2:0] ST_LS_ON  = 3'd3;
    localparam logic [2:0] ST_DT_L2H = 3'd4;
`ifdef DTG_FAULT_EN
    localparam logic [2:0] ST_FAULT  = 3'd5;
`endif

    logic            en;
    logic            inv;
    logic [DT_W-1:0] dt_reg;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_nxt;
    logic [2:0]      state;
    logic [2:0]      st_nxt;
    logic            fault_lat;
    logic            wr_ctrl;
    logic            wr_dt;
    logic            unused_wdata;

    assign wr_ctrl      = i_sel && i_we && (i_addr == 4'h0);
    assign wr_dt        = i_sel && i_we && (i_addr == 4'h4);
    assign unused_wdata = ^i_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en     <= 1'b0;
            inv    <= 1'b0;
            dt_reg <= DT_W'(DT_RESET);
        end else begin
            if (wr_ctrl) begin
                en  <= i_wdata[0];
                inv <= i_wdata[1];
            end
            if (wr_dt) begin
                dt_reg <= i_wdata[DT_W-1:0];
            end
        end
    end

`ifdef DTG_FAULT_EN
    logic       fault_clr;
    logic [1:0] fault_sync;

    assign fault_clr = wr_ctrl && i_wdata[2];

    // Synchroniser idles at 1 so reset never looks like a fault.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fault_sync <= 2'b11;
            fault_lat  <= 1'b0;
        end else begin
            fault_sync <= {fault_sync[0], fault_n};
            if (!fault_sync[1]) begin
                fault_lat <= 1'b1;
            end else if ((state == ST_FAULT) && fault_clr) begin
                fault_lat <= 1'b0;
            end
        end
    end
`else
    assign fault_lat = 1'b0;
`endif

    always_comb begin
        st_nxt  = state;
        cnt_nxt = cnt;
        case (state)
            ST_OFF: if (en) begin
                st_nxt  = pwm_in ? ST_DT_L2H : ST_DT_H2L;
                cnt_nxt = dt_reg;
            end
            ST_HS_ON: if (!pwm_in) begin
                st_nxt  = ST_DT_H2L;
                cnt_nxt = dt_reg;
            end
            ST_LS_ON: if (pwm_in) begin
                st_nxt  = ST_DT_L2H;
                cnt_nxt = dt_reg;
            end
            // A reversal during the gap returns straight to the side it left: short pulses are swallowed.
            ST_DT_H2L: if (pwm_in) begin
                st_nxt  = ST_HS_ON;
                cnt_nxt = '0;
            end else if (cnt <= DT_W'(1)) begin
                st_nxt  = ST_LS_ON;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt - DT_W'(1);
            end
            ST_DT_L2H: if (!pwm_in) begin
                st_nxt  = ST_LS_ON;
                cnt_nxt = '0;
            end else if (cnt <= DT_W'(1)) begin
                st_nxt  = ST_HS_ON;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt - DT_W'(1);
            end
`ifdef DTG_FAULT_EN
            ST_FAULT: if (fault_clr && fault_sync[1]) begin
                st_nxt = ST_OFF;
            end
`endif
            default: begin
                st_nxt  = ST_OFF;
                cnt_nxt = '0;
            end
        endcase
`ifdef DTG_FAULT_EN
        if (!fault_sync[1]) begin
            st_nxt  = ST_FAULT;
            cnt_nxt = '0;
        end else if (!en && (state != ST_FAULT)) begin
`else
        if (!en) begin
`endif
            st_nxt  = ST_OFF;
            cnt_nxt = '0;
        end
    end

    // Pins are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_OFF;
            cnt    <= '0;
            hs_out <= 1'b0;
            ls_out <= 1'b0;
        end else begin
            state  <= st_nxt;
            cnt    <= cnt_nxt;
            hs_out <= (st_nxt == ST_HS_ON) ^ inv;
            ls_out <= (st_nxt == ST_LS_ON) ^ inv;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_sel && !i_we) begin
            case (i_addr)
                4'h0: o_rdata[1:0] = {inv, en};
                4'h4: o_rdata[DT_W-1:0] = dt_reg;
                4'h8: begin
                    o_rdata[2:0]          = state;
                    o_rdata[3]            = fault_lat;
                    o_rdata[DT_W+15:16]   = cnt;
                end
                default: o_rdata = '0;
            endcase
        end
    end
endmodule
